// File: rtl/lbuf_rd_req.sv
`default_nettype none
// ============================================================================
// Module   : lbuf_rd_req
// Purpose  : Splits a host buffer descriptor into PCIe memory-read requests
//            paced by outstanding-tag credits. Define LBUF_RD_REQ_STATS_EN
//            to add the req_cnt accepted-request counter.
// Revision : 1.0
// ============================================================================
module lbuf_rd_req #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int TAG_W           = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lbuf_en,
  input  logic [63:0]      lbuf_addr,
  input  logic [31:0]      lbuf_len,
  output logic             lbuf_dn,
  output logic             rd_lbuf,
  input  logic             wt_lbuf,
  input  logic [2:0]       max_rd_req,
  output logic             req_valid,
  output logic [63:0]      req_addr,
  output logic [10:0]      req_dws,
  output logic [TAG_W-1:0] req_tag,
  input  logic             req_ack,
  input  logic             cpl_done
`ifdef LBUF_RD_REQ_STATS_EN
  ,
  output logic [31:0]      req_cnt
`endif
);

  localparam int                 c_out_w   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [c_out_w-1:0] c_max_out = c_out_w'(MAX_OUTSTANDING);
  localparam logic [c_out_w-1:0] c_out_one = c_out_w'(1);
  localparam logic [TAG_W-1:0]   c_tag_one = TAG_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ANNOUNCE = 3'd1,
    ST_CALC     = 3'd2,
    ST_ISSUE    = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [63:0]        r_addr;
  logic [32:0]        r_rem;
  logic [10:0]        r_mrrs;
  logic [10:0]        r_chunk;
  logic [TAG_W-1:0]   r_tag;
  logic [c_out_w-1:0] r_out;

  logic               w_start;
  logic               w_accept;
  logic               w_cpl;
  logic [10:0]        w_mrrs;
  logic [10:0]        w_dw_to_4k;
  logic [10:0]        w_lim;
  logic [10:0]        w_chunk;

  // Encodings 5..7 all saturate at the 1024-DW maximum request size.
  assign w_mrrs     = (max_rd_req >= 3'd5) ? 11'd1024 : (11'd32 << max_rd_req);
  assign w_dw_to_4k = 11'd1024 - {1'b0, r_addr[11:2]};
  assign w_lim      = (w_dw_to_4k < r_mrrs) ? w_dw_to_4k : r_mrrs;
  assign w_chunk    = (r_rem < {22'd0, w_lim}) ? r_rem[10:0] : w_lim;
  assign w_cpl      = cpl_done && (r_out != '0);

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (lbuf_en && !wt_lbuf) begin
          // Empty descriptors are retired straight away without announcing.
          if (lbuf_len == 32'd0) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_ANNOUNCE;
            w_start     = 1'b1;
          end
        end
      end
      ST_ANNOUNCE: begin
        if (wt_lbuf) w_state_nxt = ST_CALC;
      end
      ST_CALC: begin
        if (r_out < c_max_out) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (req_ack) begin
          w_accept    = 1'b1;
          w_state_nxt = (r_rem == {22'd0, r_chunk}) ? ST_DONE : ST_CALC;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= 64'd0;
      r_rem   <= 33'd0;
      r_mrrs  <= 11'd0;
      r_chunk <= 11'd0;
      r_tag   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_addr <= lbuf_addr;
        r_rem  <= {lbuf_len, 1'b0};
        r_mrrs <= w_mrrs;
      end
      if (r_state == ST_CALC) begin
        r_chunk <= w_chunk;
      end
      if (w_accept) begin
        r_addr <= r_addr + {51'd0, r_chunk, 2'b00};
        r_rem  <= r_rem - {22'd0, r_chunk};
        r_tag  <= r_tag + c_tag_one;
      end
    end
  end

  // Credit count survives across buffers; a return with nothing in flight is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= '0;
    end else if (w_accept && !w_cpl) begin
      r_out <= r_out + c_out_one;
    end else if (!w_accept && w_cpl) begin
      r_out <= r_out - c_out_one;
    end
  end

`ifdef LBUF_RD_REQ_STATS_EN
  logic [31:0] r_req_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_cnt <= 32'd0;
    end else if (w_accept) begin
      r_req_cnt <= r_req_cnt + 32'd1;
    end
  end

  assign req_cnt = r_req_cnt;
`endif

  assign lbuf_dn   = (r_state == ST_DONE);
  assign rd_lbuf   = (r_state == ST_ANNOUNCE);
  assign req_valid = (r_state == ST_ISSUE);
  assign req_addr  = r_addr;
  assign req_dws   = r_chunk;
  assign req_tag   = r_tag;

endmodule
`default_nettype wire

// File: doc/lbuf_rd_req.md
Name: lbuf_rd_req

Overview:
Requester side of the host-buffer pull path. Takes a host buffer descriptor (lbuf_addr/lbuf_len), splits it into PCIe memory-read requests, and hands each request to the TLP formatter over a valid/ack handshake. It announces the buffer to the completion monitor with the rd_lbuf/wt_lbuf handshake and paces requests with an outstanding-tag credit count that cpl_done returns.

Parameters:
MAX_OUTSTANDING, 8, maximum number of read requests in flight (1..32).
TAG_W, 5, width of the request tag.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
lbuf_en  in  1  new buffer descriptor valid; held until lbuf_dn
lbuf_addr  in  64  buffer base address in bytes, QW aligned
lbuf_len  in  32  buffer length in QWs
lbuf_dn  out  1  one-cycle pulse: descriptor consumed
rd_lbuf  out  1  buffer announced to the completion monitor
wt_lbuf  in  1  monitor has latched the buffer and is busy with it
max_rd_req  in  3  PCIe MRRS encoding, 128<<n bytes
req_valid  out  1  read request valid
req_addr  out  64  request byte address
req_dws  out  11  request length in DWs (1..1024)
req_tag  out  TAG_W  request tag
req_ack  in  1  formatter accepted the request
cpl_done  in  1  one request's completions fully received (credit return)

Behaviour:
- Reset values: lbuf_dn=0, rd_lbuf=0, req_valid=0, req_addr=0, req_dws=0, req_tag=0. Internally, outstanding count=0, FSM=IDLE. Reset mid-operation abandons the buffer; no lbuf_dn is issued.
- Total DW count = lbuf_len*2, held in a 33-bit remaining counter.
- MRRS DW limit = 32<<max_rd_req. Encodings 6 and 7 clamp to 1024 DW. The value is sampled in IDLE at buffer start.
- Chunk = min(remaining, mrrs_dw, dw_to_4k), where dw_to_4k = (4096 - addr[11:0])>>2. A request never crosses a 4 KB boundary.
- IDLE:
  - Wait for lbuf_en=1 and wt_lbuf=0.
  - If lbuf_len==0: pulse lbuf_dn; rd_lbuf is not asserted; stay in IDLE for one cycle so lbuf_en can drop.
  - Otherwise: latch addr, remaining and mrrs; set rd_lbuf=1; go to ANNOUNCE.
- ANNOUNCE: hold rd_lbuf=1 and stable until wt_lbuf=1, then set rd_lbuf=0 and go to CALC.
- CALC:
  - Register the chunk.
  - If outstanding < MAX_OUTSTANDING, go to ISSUE; otherwise stay in CALC.
- ISSUE:
  - Drive req_valid=1 with addr/chunk/tag. All request fields stay stable while valid and ack is low.
  - On req_ack: req_valid=0, addr += chunk*4, remaining -= chunk, tag += 1 (wraps mod 2^TAG_W).
  - Then go to CALC if remaining != 0, otherwise go to DONE.
- DONE: pulse lbuf_dn for one cycle, then go to IDLE.
- Timing: first req_valid is asserted 2 cycles after wt_lbuf is seen. Minimum spacing between requests is 2 cycles (CALC + ISSUE).
- Outstanding count:
  - +1 on req_ack, -1 on cpl_done; both in the same cycle leaves it unchanged.
  - cpl_done at count 0 is ignored and the count stays 0.
  - The count persists across buffers.
- A new buffer is not announced while wt_lbuf=1 (the monitor is still busy with the previous buffer).
- req_ack while req_valid=0 is ignored.

Optional Feature:
LBUF_RD_REQ_STATS_EN.
- Defined: adds output req_cnt[31:0], which counts accepted requests (req_ack with req_valid), wraps at 2^32, and resets to 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- addr=0x1000, len=64 QW, max_rd_req=0 → 4 requests of 32 DW at 0x1000/0x1080/0x1100/0x1180, tags 0..3, then one lbuf_dn pulse.
- addr=0x0F80, len=64 QW, max_rd_req=2 → requests 32 DW @0x0F80 then 96 DW @0x1000 (4 KB split).
- MAX_OUTSTANDING=2, len=128 QW, MRRS=128 B, no cpl_done → exactly 2 acks, then req_valid stays low; one cpl_done → third request issued.
- lbuf_len=0 → lbuf_dn pulse, rd_lbuf never asserted, no req_valid.
- wt_lbuf held high from the previous buffer while lbuf_en=1 → rd_lbuf stays 0 until wt_lbuf drops. Then rd_lbuf rises, and falls one cycle after wt_lbuf=1.
- rst asserted during ISSUE with req_ack low → all outputs 0 immediately (asynchronously). After release, a new descriptor restarts from tag 0.
